// File: rtl/sargantana_icache_pkg.sv
// Shared instruction-cache parameters, state encoding and helpers for the tag controller.
// Replacement policy selection macro: SARGANTANA_ITAG_LFSR_REPL_EN (consumed by sargantana_icache_repl).
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY   = 4;
  localparam int TAG_WIDHT      = 8;
  localparam int TAG_ADDR_WIDHT = 6;
  localparam int WAY_IDX_W      = $clog2(ICACHE_N_WAY);

  typedef logic [WAY_IDX_W-1:0] way_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    FLUSH,
    FLUSH_WAIT
  } itag_ctrl_state_t;

  function automatic logic [ICACHE_N_WAY-1:0] way_onehot(input way_idx_t idx);
    logic [ICACHE_N_WAY-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/sargantana_icache_repl.sv
// Replacement pointer: round-robin counter by default, 8-bit Fibonacci LFSR when
// SARGANTANA_ITAG_LFSR_REPL_EN is defined. Advances once per refill.
module sargantana_icache_repl
  import sargantana_icache_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     advance_i,
  output way_idx_t way_o
);

`ifdef SARGANTANA_ITAG_LFSR_REPL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Taps 8,6,5,4 counted from 1 at the LSB.
  always_comb begin
    lfsr_d = lfsr_q;
    if (advance_i) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign way_o = lfsr_q[WAY_IDX_W-1:0];
`else
  way_idx_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (advance_i) cnt_d = (cnt_q == way_idx_t'(ICACHE_N_WAY - 1)) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign way_o = cnt_q;
`endif

endmodule

// File: rtl/sargantana_itag_ctrl.sv
// Instruction-cache tag controller: sequences lookups, refills and whole-array flushes.
// Define SARGANTANA_ITAG_LFSR_REPL_EN to select the LFSR replacement pointer.
module sargantana_itag_ctrl
  import sargantana_icache_pkg::*;
(
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    lookup_valid_i,
  output logic                                    lookup_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0]               lookup_idx_i,
  input  logic [TAG_WIDHT-1:0]                    lookup_tag_i,
  output logic                                    resp_valid_o,
  output logic                                    resp_hit_o,
  output logic [ICACHE_N_WAY-1:0]                 resp_way_o,
  input  logic                                    refill_valid_i,
  output logic                                    refill_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0]               refill_idx_i,
  input  logic [TAG_WIDHT-1:0]                    refill_tag_i,
  input  logic                                    flush_req_i,
  output logic                                    flush_done_o,
  output logic [ICACHE_N_WAY-1:0]                 tag_req_o,
  output logic                                    tag_we_o,
  output logic                                    tag_vbit_o,
  output logic                                    tag_flush_o,
  output logic [TAG_WIDHT-1:0]                    tag_data_o,
  output logic [TAG_ADDR_WIDHT-1:0]               tag_addr_o,
  input  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0]  tag_way_i,
  input  logic [ICACHE_N_WAY-1:0]                 tag_vbit_i
);

  itag_ctrl_state_t          state_q, state_d;
  logic [TAG_WIDHT-1:0]      tag_q;
  way_idx_t                  victim_q, victim_d;
  logic                      flush_done_q;
  logic                      flush_armed_q;
  logic                      lookup_fire;
  logic [ICACHE_N_WAY-1:0]   match;
  way_idx_t                  repl_way;

  sargantana_icache_repl u_repl (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .advance_i ((state_q == REFILL) && !rst_i),
    .way_o     (repl_way)
  );

  // Lowest invalid way wins; the replacement pointer is used only when every way is valid.
  always_comb begin
    victim_d = repl_way;
    match    = '0;
    for (int w = ICACHE_N_WAY - 1; w >= 0; w--) begin
      if (!tag_vbit_i[w]) victim_d = way_idx_t'(w);
    end
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      match[w] = tag_vbit_i[w] && (tag_way_i[w] == tag_q);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    lookup_fire    = 1'b0;
    lookup_ready_o = 1'b0;
    refill_ready_o = 1'b0;
    resp_valid_o   = 1'b0;
    resp_hit_o     = 1'b0;
    resp_way_o     = '0;
    tag_req_o      = '0;
    tag_we_o       = 1'b0;
    tag_vbit_o     = 1'b0;
    tag_flush_o    = 1'b0;
    tag_data_o     = '0;
    tag_addr_o     = '0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE, LOOKUP: begin
          if (state_q == LOOKUP) begin
            resp_valid_o = 1'b1;
            resp_way_o   = match;
            resp_hit_o   = |match;
          end
          lookup_ready_o = !flush_req_i && !refill_valid_i;
          refill_ready_o = !flush_req_i;
          // A held flush request stalls everything until it drops and can re-arm.
          if (flush_req_i)         state_d = flush_armed_q ? FLUSH : IDLE;
          else if (refill_valid_i) state_d = REFILL;
          else if (lookup_valid_i) begin
            state_d     = LOOKUP;
            lookup_fire = 1'b1;
            tag_req_o   = '1;
            tag_addr_o  = lookup_idx_i;
          end else                 state_d = IDLE;
        end
        REFILL: begin
          tag_req_o  = way_onehot(victim_q);
          tag_we_o   = 1'b1;
          tag_vbit_o = 1'b1;
          tag_data_o = refill_tag_i;
          tag_addr_o = refill_idx_i;
          state_d    = IDLE;
        end
        FLUSH: begin
          tag_flush_o = 1'b1;
          state_d     = FLUSH_WAIT;
        end
        FLUSH_WAIT: state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      victim_q      <= '0;
      flush_done_q  <= 1'b0;
      flush_armed_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      flush_done_q <= (state_q == FLUSH_WAIT);
      if (lookup_fire) tag_q <= lookup_tag_i;
      if ((state_q == LOOKUP) && !(|match)) victim_q <= victim_d;
      if (state_d == FLUSH)  flush_armed_q <= 1'b0;
      else if (!flush_req_i) flush_armed_q <= 1'b1;
    end
  end

  assign flush_done_o = flush_done_q && !rst_i;

endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Self-checking bench for sargantana_itag_ctrl (default round-robin build): directed vector
// table, multi-cycle corner sequences and randomized traffic against a cache-level model.
module tb_sargantana_itag_ctrl;
  import sargantana_icache_pkg::*;

  localparam int NW   = ICACHE_N_WAY;
  localparam int NIDX = 1 << TAG_ADDR_WIDHT;

  logic                               clk_i = 1'b0;
  logic                               rst_i;
  logic                               lookup_valid_i, lookup_ready_o;
  logic [TAG_ADDR_WIDHT-1:0]          lookup_idx_i;
  logic [TAG_WIDHT-1:0]               lookup_tag_i;
  logic                               resp_valid_o, resp_hit_o;
  logic [NW-1:0]                      resp_way_o;
  logic                               refill_valid_i, refill_ready_o;
  logic [TAG_ADDR_WIDHT-1:0]          refill_idx_i;
  logic [TAG_WIDHT-1:0]               refill_tag_i;
  logic                               flush_req_i, flush_done_o;
  logic [NW-1:0]                      tag_req_o;
  logic                               tag_we_o, tag_vbit_o, tag_flush_o;
  logic [TAG_WIDHT-1:0]               tag_data_o;
  logic [TAG_ADDR_WIDHT-1:0]          tag_addr_o;
  logic [NW-1:0][TAG_WIDHT-1:0]       tag_way_i;
  logic [NW-1:0]                      tag_vbit_i;

  sargantana_itag_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_idx_i(lookup_idx_i), .lookup_tag_i(lookup_tag_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_way_o(resp_way_o),
    .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
    .refill_idx_i(refill_idx_i), .refill_tag_i(refill_tag_i),
    .flush_req_i(flush_req_i), .flush_done_o(flush_done_o),
    .tag_req_o(tag_req_o), .tag_we_o(tag_we_o), .tag_vbit_o(tag_vbit_o),
    .tag_flush_o(tag_flush_o), .tag_data_o(tag_data_o), .tag_addr_o(tag_addr_o),
    .tag_way_i(tag_way_i), .tag_vbit_i(tag_vbit_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Tag memory contents seen by the DUT plus the cache-level replacement model.
  logic [TAG_WIDHT-1:0] mem_t [NW][NIDX];
  logic                 mem_v [NW][NIDX];
  int                   exp_victim;
  int                   rr;

  typedef struct {
    logic                      lv;
    logic [TAG_ADDR_WIDHT-1:0] lidx;
    logic [TAG_WIDHT-1:0]      ltag;
    logic                      rv;
    logic [TAG_ADDR_WIDHT-1:0] ridx;
    logic [TAG_WIDHT-1:0]      rtag;
    logic                      fr;
    logic                      e_lrdy;
    logic                      e_rrdy;
    logic                      e_rv;
    logic                      e_hit;
    logic [NW-1:0]             e_way;
    logic [NW-1:0]             e_req;
    logic                      e_we;
    logic                      e_fl;
    logic                      e_done;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ends one cycle: applies the DUT's memory commands, then returns 1 time unit after the edge
  // with read data for the previous request (random noise when nothing was read).
  task automatic tick();
    logic                      rd;
    logic [TAG_ADDR_WIDHT-1:0] ra;
    rd = (tag_req_o != '0) && !tag_we_o;
    ra = tag_addr_o;
    if (tag_we_o)
      for (int w = 0; w < NW; w++)
        if (tag_req_o[w]) begin
          mem_v[w][tag_addr_o] = tag_vbit_o;
          mem_t[w][tag_addr_o] = tag_data_o;
        end
    if (tag_flush_o)
      for (int w = 0; w < NW; w++)
        for (int i = 0; i < NIDX; i++) mem_v[w][i] = 1'b0;
    @(posedge clk_i);
    #1;
    for (int w = 0; w < NW; w++) begin
      if (rd) begin
        tag_way_i[w]  = mem_t[w][ra];
        tag_vbit_i[w] = mem_v[w][ra];
      end else begin
        tag_way_i[w]  = TAG_WIDHT'($urandom);
        tag_vbit_i[w] = 1'($urandom);
      end
    end
  endtask

  function automatic logic [NW-1:0] exp_match(input int idx, input logic [TAG_WIDHT-1:0] tag);
    logic [NW-1:0] m;
    for (int w = 0; w < NW; w++) m[w] = mem_v[w][idx] && (mem_t[w][idx] == tag);
    return m;
  endfunction

  function automatic int pick_victim(input int idx);
    for (int w = 0; w < NW; w++) if (!mem_v[w][idx]) return w;
    return rr % NW;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1; lookup_valid_i = 1'b1; refill_valid_i = 1'b1; flush_req_i = 1'b0;
    #1;
    check("rst_lookup_ready", lookup_ready_o, 0);
    check("rst_refill_ready", refill_ready_o, 0);
    check("rst_tag_req", tag_req_o, 0);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_flush_done", flush_done_o, 0);
    tick();
    lookup_valid_i = 1'b0; refill_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
    exp_victim = 0;
    rr = 0;
  endtask

  task automatic do_lookup(input logic [TAG_ADDR_WIDHT-1:0] idx, input logic [TAG_WIDHT-1:0] tag);
    logic [NW-1:0] em;
    lookup_valid_i = 1'b1; lookup_idx_i = idx; lookup_tag_i = tag;
    #1;
    check("lk_ready", lookup_ready_o, 1);
    check("lk_req", tag_req_o, {NW{1'b1}});
    check("lk_addr", tag_addr_o, idx);
    check("lk_we", tag_we_o, 0);
    em = exp_match(idx, tag);
    if (em == '0) exp_victim = pick_victim(idx);
    tick();
    lookup_valid_i = 1'b0;
    #1;
    check("lk_resp_valid", resp_valid_o, 1);
    check("lk_resp_way", resp_way_o, em);
    check("lk_resp_hit", resp_hit_o, |em);
  endtask

  task automatic do_refill(input logic [TAG_ADDR_WIDHT-1:0] idx, input logic [TAG_WIDHT-1:0] tag,
                           input logic [NW-1:0] exp_oh);
    refill_valid_i = 1'b1; refill_idx_i = idx; refill_tag_i = tag;
    #1;
    check("rf_ready", refill_ready_o, 1);
    check("rf_lookup_blocked", lookup_ready_o, 0);
    check("rf_no_write_yet", tag_we_o, 0);
    tick();
    refill_valid_i = 1'b0;
    #1;
    check("rf_way", tag_req_o, exp_oh);
    check("rf_we", tag_we_o, 1);
    check("rf_vbit", tag_vbit_o, 1);
    check("rf_data", tag_data_o, tag);
    check("rf_addr", tag_addr_o, idx);
    check("rf_busy", refill_ready_o, 0);
    tick();
    rr = rr + 1;
  endtask

  task automatic do_flush();
    flush_req_i = 1'b1;
    #1;
    check("fl_lookup_blocked", lookup_ready_o, 0);
    check("fl_refill_blocked", refill_ready_o, 0);
    tick();
    flush_req_i = 1'b0;
    #1;
    check("fl_pulse", tag_flush_o, 1);
    tick();
    #1;
    check("fl_pulse_end", tag_flush_o, 0);
    check("fl_done_early", flush_done_o, 0);
    tick();
    #1;
    check("fl_done", flush_done_o, 1);
    check("fl_ready_after", lookup_ready_o, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    lookup_idx_i = '0; lookup_tag_i = '0; refill_idx_i = '0; refill_tag_i = '0;
    tag_way_i = '0; tag_vbit_i = '0;
    for (int w = 0; w < NW; w++)
      for (int i = 0; i < NIDX; i++) begin
        mem_t[w][i] = '0;
        mem_v[w][i] = 1'b0;
      end

    //           lv    lidx   ltag    rv    ridx   rtag    fr    lrdy  rrdy  rv    hit   way      req      we    fl    done
    vecs[0]  = '{1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 6'd5, 8'h12, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 6'd0, 8'h00, 1'b1, 6'd5, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 6'd0, 8'h00, 1'b0, 6'd5, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 6'd5, 8'h12, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 6'd5, 8'h34, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 6'd9, 8'h12, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 6'd5, 8'h12, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};

    do_reset();

    for (int i = 0; i < 16; i++) begin
      lookup_valid_i = vecs[i].lv; lookup_idx_i = vecs[i].lidx; lookup_tag_i = vecs[i].ltag;
      refill_valid_i = vecs[i].rv; refill_idx_i = vecs[i].ridx; refill_tag_i = vecs[i].rtag;
      flush_req_i    = vecs[i].fr;
      #1;
      check($sformatf("v%0d_lookup_ready", i), lookup_ready_o, vecs[i].e_lrdy);
      check($sformatf("v%0d_refill_ready", i), refill_ready_o, vecs[i].e_rrdy);
      check($sformatf("v%0d_resp_valid", i), resp_valid_o, vecs[i].e_rv);
      if (vecs[i].e_rv) begin
        check($sformatf("v%0d_resp_hit", i), resp_hit_o, vecs[i].e_hit);
        check($sformatf("v%0d_resp_way", i), resp_way_o, vecs[i].e_way);
      end
      check($sformatf("v%0d_tag_req", i), tag_req_o, vecs[i].e_req);
      check($sformatf("v%0d_tag_we", i), tag_we_o, vecs[i].e_we);
      check($sformatf("v%0d_tag_vbit", i), tag_vbit_o, vecs[i].e_we);
      check($sformatf("v%0d_tag_flush", i), tag_flush_o, vecs[i].e_fl);
      check($sformatf("v%0d_flush_done", i), flush_done_o, vecs[i].e_done);
      if (vecs[i].e_req != '0) begin
        check($sformatf("v%0d_tag_addr", i), tag_addr_o, vecs[i].e_we ? vecs[i].ridx : vecs[i].lidx);
        if (vecs[i].e_we) check($sformatf("v%0d_tag_data", i), tag_data_o, vecs[i].rtag);
      end
      tick();
    end
    lookup_valid_i = 1'b0; refill_valid_i = 1'b0; flush_req_i = 1'b0;

    // Single-way hit in way 2, then a multi-way hit.
    do_reset();
    mem_t[2][5] = 8'h12; mem_v[2][5] = 1'b1;
    do_lookup(6'd5, 8'h12);
    check("single_hit_way2", resp_way_o, 4'b0100);
    mem_t[1][7] = 8'h55; mem_v[1][7] = 1'b1;
    mem_t[3][7] = 8'h55; mem_v[3][7] = 1'b1;
    do_lookup(6'd7, 8'h55);
    check("multi_hit_ways", resp_way_o, 4'b1010);
    check("multi_hit_flag", resp_hit_o, 1);
    tick();

    // Flush held high completes once and does not re-trigger until released.
    flush_req_i = 1'b1;
    #1;
    tick();
    #1;
    check("held_fl_pulse", tag_flush_o, 1);
    tick();
    tick();
    #1;
    check("held_fl_done", flush_done_o, 1);
    check("held_fl_stall", lookup_ready_o, 0);
    tick();
    #1;
    check("held_fl_no_retrigger", tag_flush_o, 0);
    check("held_fl_still_stalled", lookup_ready_o, 0);
    tick();
    flush_req_i = 1'b0;
    #1;
    check("held_fl_released", lookup_ready_o, 1);
    tick();

    // Reset landing in FLUSH_WAIT suppresses the completion pulse.
    flush_req_i = 1'b1;
    #1;
    tick();
    flush_req_i = 1'b0;
    #1;
    check("rstfw_pulse", tag_flush_o, 1);
    tick();
    rst_i = 1'b1;
    #1;
    check("rstfw_done_in_reset", flush_done_o, 0);
    tick();
    rst_i = 1'b0;
    #1;
    check("rstfw_no_done", flush_done_o, 0);
    check("rstfw_idle", lookup_ready_o, 1);
    tick();

    // Reset landing in REFILL suppresses the write.
    refill_valid_i = 1'b1; refill_idx_i = 6'd3; refill_tag_i = 8'h99;
    #1;
    tick();
    refill_valid_i = 1'b0; rst_i = 1'b1;
    #1;
    check("rstrf_no_we", tag_we_o, 0);
    check("rstrf_no_req", tag_req_o, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // Refill with no miss since reset targets way 0.
    do_reset();
    do_refill(6'd3, 8'h44, 4'b0001);

    // All-valid misses follow the round-robin pointer: ways 0,1,2,3,0.
    do_reset();
    for (int w = 0; w < NW; w++) begin
      mem_t[w][10] = 8'hA0 + 8'(w);
      mem_v[w][10] = 1'b1;
    end
    begin
      logic [NW-1:0] rr_seq [5];
      rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
      rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
      for (int i = 0; i < 5; i++) begin
        do_lookup(6'd10, 8'h77);
        do_refill(6'd10, 8'hC0 + 8'(i), rr_seq[i]);
      end
    end

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int op;
      op = int'($urandom_range(0, 11));
      if (op <= 5)
        do_lookup(TAG_ADDR_WIDHT'($urandom_range(0, 3)), 8'h10 + 8'($urandom_range(0, 3)));
      else if (op <= 8)
        do_refill(TAG_ADDR_WIDHT'($urandom_range(0, 3)), 8'h10 + 8'($urandom_range(0, 3)),
                  way_onehot(way_idx_t'(exp_victim)));
      else if (op == 9)
        do_flush();
      else begin
        #1;
        tick();
      end
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sargantana_itag_ctrl.md
SARGANTANA_ITAG_CTRL -- requirements
Module: sargantana_itag_ctrl

Interface
REQ-001 Ports SHALL be (name direction width meaning), in this order; clock and reset: one clock; reset is synchronous and active-high.
- clk_i in 1: clock, all state on rising edge.
- rst_i in 1: synchronous active-high reset.
- lookup_valid_i in 1 / lookup_ready_o out 1: lookup handshake.
- lookup_idx_i in TAG_ADDR_WIDHT: set index. lookup_tag_i in TAG_WIDHT: tag to compare.
- resp_valid_o out 1: one-cycle result pulse. resp_hit_o out 1: hit. resp_way_o out ICACHE_N_WAY: one-hot hit way.
- refill_valid_i in 1 / refill_ready_o out 1: refill handshake. refill_idx_i in TAG_ADDR_WIDHT, refill_tag_i in TAG_WIDHT.
- flush_req_i in 1: level request, invalidate all tags. flush_done_o out 1: one-cycle completion pulse.
- tag_req_o out ICACHE_N_WAY, tag_we_o out 1, tag_vbit_o out 1, tag_flush_o out 1, tag_data_o out TAG_WIDHT, tag_addr_o out TAG_ADDR_WIDHT: drive the per-way tag memory.
- tag_way_i in ICACHE_N_WAY x TAG_WIDHT, tag_vbit_i in ICACHE_N_WAY: tag memory read data, valid one cycle after request.

Function
REQ-002 FSM states SHALL be IDLE, LOOKUP, REFILL, FLUSH, FLUSH_WAIT.
REQ-003 Priority on each cycle in IDLE/LOOKUP SHALL be flush_req_i > refill_valid_i > lookup_valid_i.
REQ-004 lookup_ready_o SHALL be 1 only in IDLE or LOOKUP with flush_req_i=0 and refill_valid_i=0.
REQ-005 Accepted lookup: same cycle tag_req_o=all ones, tag_we_o=0, tag_addr_o=lookup_idx_i; idx/tag registered; next state LOOKUP.
REQ-006 In LOOKUP: match[w]=tag_vbit_i[w] & (tag_way_i[w]==registered tag); resp_valid_o=1, resp_way_o=match, resp_hit_o=|match; latency exactly 1 cycle after acceptance; back-to-back lookups give one response per cycle.
REQ-007 On miss, victim SHALL be latched: lowest-index way with tag_vbit_i=0; if all valid, the replacement pointer way.
REQ-008 Accepted refill (refill_ready_o=1 in IDLE/LOOKUP when flush_req_i=0): state REFILL for one cycle: tag_req_o=one-hot latched victim, tag_we_o=1, tag_vbit_o=1, tag_data_o=refill_tag_i, tag_addr_o=refill_idx_i; replacement pointer advances; then IDLE.
REQ-009 Refill with no preceding miss since reset SHALL write way 0.
REQ-010 Flush: FLUSH asserts tag_flush_o=1 for exactly one cycle, FLUSH_WAIT one cycle, flush_done_o=1 on FLUSH_WAIT exit, then IDLE; flush_req_i held high re-triggers only after deassertion.
REQ-011 Flush requested while in LOOKUP SHALL still emit that lookup's response before FLUSH.
REQ-012 Multiple matches SHALL report all matching bits in resp_way_o, resp_hit_o=1.
REQ-013 Outside REQ-005/008/010 all tag_* outputs SHALL be 0.

Reset
REQ-014 rst_i=1 SHALL force IDLE, all outputs 0, victim=way 0, pointer to seed; mid-flush/refill reset aborts with no flush_done_o or write.

Configuration
REQ-015 Macro SARGANTANA_ITAG_LFSR_REPL_EN defined: pointer is 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'hA5, way = low log2(ICACHE_N_WAY) bits; undefined: round-robin counter, reset 0, +1 per refill, wrap at ICACHE_N_WAY-1.

Structure
REQ-016 ICACHE_N_WAY, TAG_WIDHT, TAG_ADDR_WIDHT and FSM state enum itag_ctrl_state_t SHALL live in sargantana_icache_pkg.
REQ-017 Replacement pointer SHALL be sub-module sargantana_icache_repl (inputs clk_i, rst_i, advance; output way index).

Verification (ICACHE_N_WAY=4)
REQ-018 Reset, lookup idx=5 tag=0x12, all vbit=0 -> next cycle resp_valid_o=1, resp_hit_o=0; refill tag=0x12 -> tag_req_o=4'b0001, tag_we_o=1.
REQ-019 Lookup idx=5 tag=0x12, tag_way_i[2]=0x12 vbit=4'b0100 -> resp_way_o=4'b0100, resp_hit_o=1.
REQ-020 Three back-to-back lookups -> three consecutive resp_valid_o pulses, no bubbles.
REQ-021 All vbit=1 miss then 5 refills, round-robin build -> victim ways 0,1,2,3,0.
REQ-022 flush_req_i during LOOKUP -> response emitted, tag_flush_o 1 cycle later, flush_done_o 2 cycles after tag_flush_o; lookup_ready_o=0 throughout.
REQ-023 rst_i in FLUSH_WAIT -> no flush_done_o, state IDLE next cycle.
